// File: rtl/lenet_pkg.sv
// Shared LeNet pipeline constants: feature-map sizes, channel count, pixel
// width, packed-window lane positions and the pooled six-channel word type.
package lenet_pkg;

  localparam int C1_DIM    = 28;
  localparam int S2_DIM    = 14;
  localparam int NUM_C1_CH = 6;
  localparam int PIX_W     = 8;

  // Lane index of each pixel inside a packed 2x2 window (lane 0 is the LSBs).
  localparam int WIN_LANE_R0C0 = 3;
  localparam int WIN_LANE_R0C1 = 2;
  localparam int WIN_LANE_R1C0 = 1;
  localparam int WIN_LANE_R1C1 = 0;

  // Bit offset of each lane for the default pixel width.
  localparam int WIN_R0C0_LSB = WIN_LANE_R0C0 * PIX_W;
  localparam int WIN_R0C1_LSB = WIN_LANE_R0C1 * PIX_W;
  localparam int WIN_R1C0_LSB = WIN_LANE_R1C0 * PIX_W;
  localparam int WIN_R1C1_LSB = WIN_LANE_R1C1 * PIX_W;

  // Width of the output row/column tags (enough for 0..S2_DIM-1).
  localparam int POS_W = 4;

  // Six pooled channels, ch5 in the top byte down to ch0 in the bottom byte.
  typedef logic [NUM_C1_CH*PIX_W-1:0] pool_word_t;

endpackage

// File: rtl/pool_out_fifo.sv
// Synchronous FIFO with a registered head. rd_data/rd_valid come straight
// from flops; when the FIFO drains, rd_data keeps the last popped word.
// A push into a full FIFO is accepted only if the head is popped in the
// same cycle; otherwise it is dropped and wr_drop pulses.
module pool_out_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     wr_drop,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [WIDTH-1:0] head_r;
  logic             head_valid_r;

  logic             full_s;
  logic             pop_s;
  logic             push_s;
  logic [PTR_W-1:0] rd_next_s;
  logic [CNT_W-1:0] count_next_s;
  logic [WIDTH-1:0] head_next_s;

  // Push/pop decisions and next pointer/count values.
  always_comb begin
    full_s    = (count_r == CNT_W'(DEPTH));
    pop_s     = head_valid_r && rd_ready;
    push_s    = wr_en && (!full_s || pop_s);
    wr_drop   = wr_en && full_s && !pop_s;
    if (pop_s) begin
      rd_next_s = rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
    end else begin
      rd_next_s = rd_ptr_r;
    end
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      2'b01:   count_next_s = count_r - {{(CNT_W-1){1'b0}}, 1'b1};
      default: count_next_s = count_r;
    endcase
  end

  // Next head word: the entry behind a popped head, a word landing in an
  // empty FIFO, or the current (possibly last popped) word held as is.
  always_comb begin
    head_next_s = head_r;
    if (pop_s) begin
      if (count_next_s != {CNT_W{1'b0}}) begin
        if (push_s && (wr_ptr_r == rd_next_s)) begin
          head_next_s = wr_data;
        end else begin
          head_next_s = mem_r[rd_next_s];
        end
      end else begin
        head_next_s = head_r;
      end
    end else if (push_s && (count_r == {CNT_W{1'b0}})) begin
      head_next_s = wr_data;
    end else begin
      head_next_s = head_r;
    end
  end

  // Storage array write; contents are only read behind valid pointers.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers, occupancy and registered head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r     <= {PTR_W{1'b0}};
      rd_ptr_r     <= {PTR_W{1'b0}};
      count_r      <= {CNT_W{1'b0}};
      head_r       <= {WIDTH{1'b0}};
      head_valid_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      rd_ptr_r     <= rd_next_s;
      count_r      <= count_next_s;
      head_r       <= head_next_s;
      head_valid_r <= (count_next_s != {CNT_W{1'b0}});
    end
  end

  assign rd_valid = head_valid_r;
  assign rd_data  = head_r;
  assign full     = full_s;
  assign empty    = (count_r == {CNT_W{1'b0}});
  assign count    = count_r;

endmodule

// File: rtl/s2_maxpool_unit.sv
// S2 2x2 max-pooling stage. Two register stages (row-pair max, then final
// max) feed a tagged output FIFO drained over valid/ready. The input side
// cannot be stalled, so results arriving at a full FIFO are dropped and the
// sticky overflow flag is raised.
// Build option: define S2_POOL_RELU_EN to clamp negative results to zero.
module s2_maxpool_unit
  import lenet_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter bit SIGNED_DATA = 1'b1,
  parameter int OUT_DIM     = 14,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          c1_reg_valid,
  input  logic [4*DATA_W-1:0]           c1_reg_out_ch_0,
  input  logic [4*DATA_W-1:0]           c1_reg_out_ch_1,
  input  logic [4*DATA_W-1:0]           c1_reg_out_ch_2,
  input  logic [4*DATA_W-1:0]           c1_reg_out_ch_3,
  input  logic [4*DATA_W-1:0]           c1_reg_out_ch_4,
  input  logic [4*DATA_W-1:0]           c1_reg_out_ch_5,
  output logic                          pool_valid,
  input  logic                          pool_ready,
  output logic [NUM_C1_CH*DATA_W-1:0]   pool_data,
  output logic [POS_W-1:0]              pool_col,
  output logic [POS_W-1:0]              pool_row,
  output logic                          pool_last,
  output logic                          overflow
);

  localparam int CH_W    = NUM_C1_CH * DATA_W;
  localparam int ENTRY_W = CH_W + 2 * POS_W + 1;
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(OUT_DIM - 1);

  // Larger of two pixels under the configured signedness.
  function automatic logic [DATA_W-1:0] pix_max(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic a_wins;
    if (SIGNED_DATA) begin
      a_wins = ($signed(a) > $signed(b));
    end else begin
      a_wins = (a > b);
    end
    return a_wins ? a : b;
  endfunction

  // Optional rectification of a pooled pixel.
  function automatic logic [DATA_W-1:0] pix_clamp(input logic [DATA_W-1:0] v);
`ifdef S2_POOL_RELU_EN
    if (SIGNED_DATA && v[DATA_W-1]) begin
      return {DATA_W{1'b0}};
    end else begin
      return v;
    end
`else
    return v;
`endif
  endfunction

  logic [4*DATA_W-1:0] win_s   [NUM_C1_CH];
  logic [DATA_W-1:0]   top_s   [NUM_C1_CH];
  logic [DATA_W-1:0]   bot_s   [NUM_C1_CH];
  logic [DATA_W-1:0]   s1_top_r[NUM_C1_CH];
  logic [DATA_W-1:0]   s1_bot_r[NUM_C1_CH];
  logic                s1_valid_r;
  logic [CH_W-1:0]     s2_next_s;
  logic [CH_W-1:0]     s2_data_r;
  logic                s2_valid_r;
  logic [POS_W-1:0]    col_r;
  logic [POS_W-1:0]    row_r;
  logic                tag_last_s;
  logic                overflow_r;
  logic                drop_s;
  logic [ENTRY_W-1:0]  fifo_wr_s;
  logic [ENTRY_W-1:0]  head_s;
  logic                fifo_full_s;
  logic                fifo_empty_s;
  logic [$clog2(FIFO_DEPTH):0] fifo_count_s;
  logic                fifo_status_unused_s;

  // Gather the six channel windows into an indexable array.
  always_comb begin
    win_s[0] = c1_reg_out_ch_0;
    win_s[1] = c1_reg_out_ch_1;
    win_s[2] = c1_reg_out_ch_2;
    win_s[3] = c1_reg_out_ch_3;
    win_s[4] = c1_reg_out_ch_4;
    win_s[5] = c1_reg_out_ch_5;
  end

  // Stage-1 compare: max of the top pixel pair and of the bottom pixel pair.
  always_comb begin
    for (int c = 0; c < NUM_C1_CH; c++) begin
      top_s[c] = pix_max(win_s[c][WIN_LANE_R0C0*DATA_W +: DATA_W],
                         win_s[c][WIN_LANE_R0C1*DATA_W +: DATA_W]);
      bot_s[c] = pix_max(win_s[c][WIN_LANE_R1C0*DATA_W +: DATA_W],
                         win_s[c][WIN_LANE_R1C1*DATA_W +: DATA_W]);
    end
  end

  // Stage-1 register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      for (int c = 0; c < NUM_C1_CH; c++) begin
        s1_top_r[c] <= {DATA_W{1'b0}};
        s1_bot_r[c] <= {DATA_W{1'b0}};
      end
    end else begin
      s1_valid_r <= c1_reg_valid;
      for (int c = 0; c < NUM_C1_CH; c++) begin
        s1_top_r[c] <= top_s[c];
        s1_bot_r[c] <= bot_s[c];
      end
    end
  end

  // Stage-2 compare: final max per channel, optionally rectified.
  always_comb begin
    s2_next_s = {CH_W{1'b0}};
    for (int c = 0; c < NUM_C1_CH; c++) begin
      s2_next_s[c*DATA_W +: DATA_W] = pix_clamp(pix_max(s1_top_r[c], s1_bot_r[c]));
    end
  end

  // Stage-2 register; its contents are committed to the FIFO next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      s2_data_r  <= {CH_W{1'b0}};
    end else begin
      s2_valid_r <= s1_valid_r;
      s2_data_r  <= s2_next_s;
    end
  end

  // Raster position of the result being committed; advances even on a drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_r <= {POS_W{1'b0}};
      row_r <= {POS_W{1'b0}};
    end else if (s2_valid_r) begin
      if (col_r == POS_MAX) begin
        col_r <= {POS_W{1'b0}};
        row_r <= (row_r == POS_MAX) ? {POS_W{1'b0}} : row_r + {{(POS_W-1){1'b0}}, 1'b1};
      end else begin
        col_r <= col_r + {{(POS_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign tag_last_s = (row_r == POS_MAX) && (col_r == POS_MAX);
  assign fifo_wr_s  = {s2_data_r, row_r, col_r, tag_last_s};

  pool_out_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (s2_valid_r),
    .wr_data (fifo_wr_s),
    .wr_drop (drop_s),
    .rd_valid(pool_valid),
    .rd_ready(pool_ready),
    .rd_data (head_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (fifo_count_s)
  );

  // Occupancy status is not needed at this level.
  assign fifo_status_unused_s = ^{fifo_full_s, fifo_empty_s, fifo_count_s};

  // Sticky loss flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end
  end

  assign {pool_data, pool_row, pool_col, pool_last} = head_s;
  assign overflow = overflow_r;

endmodule
